ddr2_cmd_sequencer: RTL and testbench

//  Closed-page DDR2 command sequencer driving the controller-to-DRAM pins (cke, cs_n/ras_n/cas_n/we_n, addr, ba).

---
 rtl/ddr2_pkg.sv | 25 ++
 rtl/ddr2_timer.sv | 18 +
 rtl/ddr2_cmd_sequencer.sv | 162 ++++++++++++++++
 tb/tb_ddr2_cmd_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ddr2_pkg.sv
// ddr2_pkg: command encodings, FSM states, address field slices and default timings
package ddr2_pkg;
  localparam int T_RCD_DEF = 3;
  localparam int T_RAS_DEF = 8;
  localparam int T_RP_DEF = 3;
  localparam int T_WR_DEF = 3;
  localparam int CL_DEF = 4;
  localparam int RD_TO_DEF = 16;
  localparam int TIMER_W = 5;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD = 4'b0101;
  localparam logic [3:0] CMD_WR = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_NOP = 4'b0111;
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_TRCD, S_WRLAT, S_RDWAIT, S_PREWAIT, S_TRP} state_t;
  function automatic logic [1:0] bank_of(input logic [24:0] a);
    return a[24:23];
  endfunction
  function automatic logic [12:0] row_of(input logic [24:0] a);
    return a[22:10];
  endfunction
  function automatic logic [12:0] col_of(input logic [24:0] a);
    return {3'b0, a[9:0]};
  endfunction
endpackage

// File: rtl/ddr2_timer.sv
// ddr2_timer: loadable down-counter; done while the count sits at zero
module ddr2_timer #(
  parameter int W = 5
) (
  input  logic         ck,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_done
);
  logic [W-1:0] r_cnt;
  // load takes priority, otherwise count down and stop at zero
  always_ff @(posedge ck)
    if (!reset) r_cnt <= '0;
    else if (i_load) r_cnt <= i_value;
    else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  assign o_done = (r_cnt == '0);
endmodule

// File: rtl/ddr2_cmd_sequencer.sv
// ddr2_cmd_sequencer: closed-page ACT -> RD/WR -> PRE sequencer with 8-beat bursts
module ddr2_cmd_sequencer
  import ddr2_pkg::*;
#(
  parameter int T_RCD = T_RCD_DEF,
  parameter int T_RAS = T_RAS_DEF,
  parameter int T_RP = T_RP_DEF,
  parameter int T_WR = T_WR_DEF,
  parameter int CL = CL_DEF,
  parameter int RD_TO = RD_TO_DEF
) (
  input  logic         ck,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [24:0]  req_addr,
  input  logic [127:0] req_wdata,
  output logic         rsp_valid,
  output logic         rsp_err,
  output logic [127:0] rsp_rdata,
  output logic         cke,
  output logic         cs_n,
  output logic         ras_n,
  output logic         cas_n,
  output logic         we_n,
  output logic [12:0]  addr,
  output logic [1:0]   ba,
  output logic         wr_data_en,
  output logic [15:0]  wr_rise,
  output logic [15:0]  wr_fall,
  input  logic         rd_beat_valid,
  input  logic [31:0]  rd_beat
);
  state_t               r_state;
  logic                 r_cke, r_init_cnt, r_req_ready, r_rsp_valid, r_rsp_err, r_wr_data_en;
  logic                 r_we, r_err;
  logic [3:0]           r_cmd;
  logic [12:0]          r_addr;
  logic [1:0]           r_ba, r_cnt;
  logic [24:0]          r_req_addr;
  logic [127:0]         r_wdata, r_rdata, r_rsp_rdata;
  logic [15:0]          r_wr_rise, r_wr_fall;
  logic                 w_accept, w_issue, w_wr_end, w_pre, w_rd_last;
  logic                 w_t0_load, w_t2_load, w_t0_done, w_ras_done, w_t2_done;
  logic [TIMER_W-1:0]   w_t0_value, w_t2_value;
  // timer 0 spaces ACT->RD/WR, WR->data and PRE->IDLE; timer 2 covers write recovery or read timeout
  always_comb begin
    w_accept = (r_state == S_IDLE) && req_valid && r_req_ready;
    w_issue = (r_state == S_TRCD) && w_t0_done;
    w_wr_end = (r_state == S_WRLAT) && r_wr_data_en && (r_cnt == 2'd0);
    w_pre = (r_state == S_PREWAIT) && w_ras_done && (!r_we || w_t2_done);
    w_rd_last = rd_beat_valid && (r_cnt == 2'd3);
    w_t0_load = w_accept || (w_issue && r_we) || w_pre;
    w_t0_value = w_accept ? TIMER_W'(T_RCD - 1) : (w_pre ? TIMER_W'(T_RP - 1) : TIMER_W'(CL - 2));
    w_t2_load = (w_issue && !r_we) || w_wr_end;
    w_t2_value = r_we ? TIMER_W'(T_WR - 2) : TIMER_W'(RD_TO - 2);
  end
  ddr2_timer #(.W(TIMER_W)) u_t0 (.ck(ck), .reset(reset), .i_load(w_t0_load), .i_value(w_t0_value), .o_done(w_t0_done));
  ddr2_timer #(.W(TIMER_W)) u_ras (.ck(ck), .reset(reset), .i_load(w_accept), .i_value(TIMER_W'(T_RAS - 1)), .o_done(w_ras_done));
  ddr2_timer #(.W(TIMER_W)) u_t2 (.ck(ck), .reset(reset), .i_load(w_t2_load), .i_value(w_t2_value), .o_done(w_t2_done));
  // command FSM: every output registered, NOP unless a command is issued this cycle
  always_ff @(posedge ck) begin
    if (!reset) begin
      r_state <= S_INIT;
      r_cke <= 1'b0;
      r_init_cnt <= 1'b0;
      r_cmd <= CMD_NOP;
      r_addr <= '0;
      r_ba <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err <= 1'b0;
      r_rsp_rdata <= '0;
      r_wr_data_en <= 1'b0;
      r_wr_rise <= '0;
      r_wr_fall <= '0;
      r_we <= 1'b0;
      r_err <= 1'b0;
      r_cnt <= '0;
      r_req_addr <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_cmd <= CMD_NOP;
      r_rsp_valid <= 1'b0;
      r_rsp_err <= 1'b0;
      case (r_state)
        S_INIT:
          if (!r_cke) r_cke <= 1'b1;
          else if (r_init_cnt) begin
            r_state <= S_IDLE;
            r_req_ready <= 1'b1;
          end else r_init_cnt <= 1'b1;
        S_IDLE:
          if (w_accept) begin
            r_we <= req_we;
            r_req_addr <= req_addr;
            r_wdata <= req_wdata;
            r_cmd <= CMD_ACT;
            r_addr <= row_of(req_addr);
            r_ba <= bank_of(req_addr);
            r_req_ready <= 1'b0;
            r_cnt <= '0;
            r_err <= 1'b0;
            r_rdata <= '0;
            r_state <= S_TRCD;
          end
        S_TRCD:
          if (w_t0_done) begin
            r_cmd <= r_we ? CMD_WR : CMD_RD;
            r_addr <= col_of(r_req_addr);
            r_state <= r_we ? S_WRLAT : S_RDWAIT;
          end
        S_WRLAT:
          if (w_wr_end) begin
            r_wr_data_en <= 1'b0;
            r_state <= S_PREWAIT;
          end else if (r_wr_data_en || w_t0_done) begin
            r_wr_data_en <= 1'b1;
            r_wr_rise <= r_wdata[{r_cnt, 5'd0} +: 16];
            r_wr_fall <= r_wdata[{r_cnt, 5'd16} +: 16];
            r_cnt <= r_cnt + 2'd1;
          end
        S_RDWAIT: begin
          if (rd_beat_valid) begin
            r_rdata[{r_cnt, 5'd0} +: 32] <= rd_beat;
            r_cnt <= r_cnt + 2'd1;
          end
          if (w_rd_last || w_t2_done) r_state <= S_PREWAIT;
          if (w_t2_done && !w_rd_last) r_err <= 1'b1;
        end
        S_PREWAIT:
          if (w_pre) begin
            r_cmd <= CMD_PRE;
            r_addr <= 13'h400;
            r_rsp_valid <= 1'b1;
            r_rsp_err <= r_err;
            r_rsp_rdata <= r_rdata;
            r_state <= S_TRP;
          end
        S_TRP:
          if (w_t0_done) begin
            r_state <= S_IDLE;
            r_req_ready <= 1'b1;
          end
        default: r_state <= S_INIT;
      endcase
    end
  end
  assign {cs_n, ras_n, cas_n, we_n} = r_cmd;
  assign cke = r_cke;
  assign addr = r_addr;
  assign ba = r_ba;
  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;
  assign wr_data_en = r_wr_data_en;
  assign wr_rise = r_wr_rise;
  assign wr_fall = r_wr_fall;
endmodule

// File: tb/tb_ddr2_cmd_sequencer.sv
// tb_ddr2_cmd_sequencer: randomized requests vs a cycle-timestamped scoreboard of expected DRAM activity
module tb_ddr2_cmd_sequencer;
  localparam int T_RCD = 3, T_RAS = 8, T_RP = 3, T_WR = 3, CL = 4, RD_TO = 16;
  logic ck = 1'b0, reset = 1'b0;
  logic req_valid, req_ready, req_we, rsp_valid, rsp_err, cke, cs_n, ras_n, cas_n, we_n;
  logic wr_data_en, rd_beat_valid;
  logic [24:0] req_addr;
  logic [127:0] req_wdata, rsp_rdata;
  logic [12:0] addr;
  logic [1:0] ba;
  logic [15:0] wr_rise, wr_fall;
  logic [31:0] rd_beat;
  typedef struct { int kind; int cyc; logic [31:0] a; logic [127:0] d; logic e; } ev_t;
  typedef struct { int n; logic [127:0] b; } rd_t;
  ev_t q[$];
  rd_t phy_q[$];
  rd_t cur;
  int cyc = 0, n_cmp = 0, n_fail = 0, ready_edge = 0, last_a = 0;

  ddr2_cmd_sequencer dut (
    .ck(ck), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata), .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
    .addr(addr), .ba(ba), .wr_data_en(wr_data_en), .wr_rise(wr_rise), .wr_fall(wr_fall),
    .rd_beat_valid(rd_beat_valid), .rd_beat(rd_beat)
  );

  always #5 ck = ~ck;
  always @(posedge ck) cyc <= cyc + 1;

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, required %h", nm, cyc, got, exp);
    end
  endtask

  task automatic chk(input int k, input logic [31:0] a, input logic [127:0] d, input logic e, input string nm);
    ev_t x;
    n_cmp++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: unexpected output at cycle %0d, got %h / %h / %b, required none", nm, cyc, a, d, e);
    end else begin
      x = q.pop_front();
      if (x.kind != k || x.cyc != cyc || x.a !== a || x.d !== d || x.e !== e) begin
        n_fail++;
        $display("FAIL %s: got kind %0d cycle %0d a=%h d=%h e=%b, required kind %0d cycle %0d a=%h d=%h e=%b",
                 nm, k, cyc, a, d, e, x.kind, x.cyc, x.a, x.d, x.e);
      end
    end
  endtask

  task automatic push(input int k, input int c, input logic [31:0] a, input logic [127:0] d, input logic e);
    ev_t x;
    x.kind = k; x.cyc = c; x.a = a; x.d = d; x.e = e;
    q.push_back(x);
  endtask

  // monitor: every non-NOP command, write beat pair and response must match the scoreboard head
  always @(negedge ck) begin
    if (reset) begin
      if ({cs_n, ras_n, cas_n, we_n} != 4'b0111) chk(0, {13'b0, cs_n, ras_n, cas_n, we_n, ba, addr}, '0, 1'b0, "cmd");
      if (wr_data_en) chk(1, {wr_fall, wr_rise}, '0, 1'b0, "wdata");
      if (rsp_valid) begin
        chk(2, 32'b0, rsp_rdata, rsp_err, "rsp");
        cmp("rsp_with_ready", 32'(req_ready), 32'd0);
      end
    end
  end

  // PHY: after each READ, return the queued beats starting CL cycles later
  initial begin
    forever begin
      @(negedge ck);
      if (reset && {cs_n, ras_n, cas_n, we_n} == 4'b0101) begin
        cur.n = 0;
        cur.b = '0;
        if (phy_q.size() > 0) cur = phy_q.pop_front();
        repeat (CL) @(posedge ck);
        for (int k = 0; k < cur.n; k++) begin
          #1 rd_beat_valid = 1'b1;
          rd_beat = cur.b[32*k +: 32];
          @(posedge ck);
        end
        #1 rd_beat_valid = 1'b0;
      end
    end
  end

  // reference: accept when ready, ACT, RD/WR after tRCD, data/beats, PRE and response per timing rules
  task automatic do_req(input logic we, input logic [24:0] ad, input logic [127:0] wd,
                        input logic [127:0] rb, input int nb, input int gap);
    int s, a, rw, pre;
    logic [127:0] exp;
    rd_t r;
    repeat (gap) begin @(posedge ck); #1; end
    s = cyc;
    req_valid = 1'b1; req_we = we; req_addr = ad; req_wdata = wd;
    a = (s + 1 > ready_edge + 1) ? s + 1 : ready_edge + 1;
    rw = a + T_RCD;
    push(0, a, {13'b0, 4'b0011, ad[24:23], ad[22:10]}, '0, 1'b0);
    push(0, rw, {13'b0, we ? 4'b0100 : 4'b0101, ad[24:23], 3'b0, ad[9:0]}, '0, 1'b0);
    exp = '0;
    if (we) begin
      for (int k = 0; k < 4; k++) push(1, rw + CL - 1 + k, {wd[16*(2*k+1) +: 16], wd[16*(2*k) +: 16]}, '0, 1'b0);
      pre = rw + CL - 1 + 3 + T_WR;
    end else begin
      r.n = nb; r.b = rb;
      phy_q.push_back(r);
      for (int k = 0; k < nb; k++) exp[32*k +: 32] = rb[32*k +: 32];
      pre = (nb == 4) ? rw + CL + 4 + 1 : rw + RD_TO;
    end
    if (pre < a + T_RAS) pre = a + T_RAS;
    push(0, pre, {13'b0, 4'b0010, ad[24:23], 13'h400}, '0, 1'b0);
    push(2, pre, 32'b0, exp, !we && nb < 4);
    ready_edge = pre + T_RP;
    last_a = a;
    while (cyc < a) begin @(posedge ck); #1; end
    req_valid = 1'b0;
  endtask

  task automatic release_rst;
    @(posedge ck);
    #1 reset = 1'b1;
    ready_edge = cyc + 3;
    @(posedge ck);
    @(negedge ck);
    cmp("init_cke", 32'(cke), 32'd1);
    cmp("init_ready0", 32'(req_ready), 32'd0);
    cmp("init_nop", 32'({cs_n, ras_n, cas_n, we_n}), 32'h7);
    @(negedge ck);
    cmp("init_ready1", 32'(req_ready), 32'd0);
    @(negedge ck);
    cmp("init_ready2", 32'(req_ready), 32'd1);
    @(posedge ck);
    #1;
  endtask

  task automatic drain;
    int t;
    t = 0;
    while (q.size() > 0 && t < 400) begin @(negedge ck); t++; end
    n_cmp++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected outputs never seen, required 0", q.size());
    end
    @(posedge ck);
    #1;
  endtask

  initial begin
    int p, nb;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rd_beat_valid = 1'b0; rd_beat = '0;
    repeat (5) @(posedge ck);
    @(negedge ck);
    cmp("rst_cke", 32'(cke), 32'd0);
    cmp("rst_nop", 32'({cs_n, ras_n, cas_n, we_n}), 32'h7);
    cmp("rst_ready", 32'(req_ready), 32'd0);
    cmp("rst_rsp", 32'(rsp_valid), 32'd0);
    cmp("rst_wden", 32'(wr_data_en), 32'd0);
    release_rst();
    do_req(1'b1, {2'd2, 13'h1A3, 10'h040},
           {16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0}, '0, 0, 0);
    do_req(1'b0, {2'd1, 13'h0055, 10'h3F8}, '0, {4{32'hBEEF_CAFE}}, 4, 2);
    do_req(1'b1, {2'd3, 13'h1FFF, 10'h3FF}, {4{$urandom}}, '0, 0, 0);
    do_req(1'b0, {2'd0, 13'h0000, 10'h000}, '0, {$urandom, $urandom, $urandom, $urandom}, 4, 0);
    do_req(1'b0, {2'd1, 13'h0ABC, 10'h155}, '0, {$urandom, $urandom, $urandom, $urandom}, 2, 1);
    for (int i = 0; i < 20; i++) begin
      p = $urandom_range(0, 5);
      nb = (p < 4) ? 4 : (p == 4 ? 2 : $urandom_range(0, 3));
      do_req(1'($urandom_range(0, 1)), 25'($urandom), {$urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom}, nb, $urandom_range(0, 3));
    end
    drain();
    do_req(1'b1, 25'($urandom), {$urandom, $urandom, $urandom, $urandom}, '0, 0, 0);
    while (cyc < last_a + T_RCD + CL) begin @(posedge ck); #1; end
    reset = 1'b0;
    @(negedge ck);
    #1 q.delete();
    phy_q.delete();
    @(negedge ck);
    cmp("midwr_cke", 32'(cke), 32'd0);
    cmp("midwr_nop", 32'({cs_n, ras_n, cas_n, we_n}), 32'h7);
    cmp("midwr_wden", 32'(wr_data_en), 32'd0);
    cmp("midwr_rsp", 32'(rsp_valid), 32'd0);
    cmp("midwr_ready", 32'(req_ready), 32'd0);
    repeat (3) begin
      @(negedge ck);
      cmp("midwr_hold_rsp", 32'(rsp_valid), 32'd0);
    end
    release_rst();
    do_req(1'b0, {2'd2, 13'h0123, 10'h2AA}, '0, {$urandom, $urandom, $urandom, $urandom}, 4, 0);
    do_req(1'b1, {2'd0, 13'h1555, 10'h0F0}, {$urandom, $urandom, $urandom, $urandom}, '0, 0, 0);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
